// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout
//  Description : Display-side reader of the framebuffer RAM. Generates VGA
//                timing, drives the RAM read address and converts the
//                returned RGB444 word into DAC colour pins. The low-resolution
//                framebuffer is upscaled by pixel and line replication.
//
//  Ports
//    clock            in   pixel clock, also the RAM read clock
//    reset            in   synchronous, active-high
//    fb_read_address  out  registered RAM read address
//    fb_data          in   RAM read data, valid one clock after the address
//    hsync / vsync    out  active-low sync pulses
//    red/green/blue   out  4-bit DAC colour, 0 while blanked
//    frame_start      out  one-clock pulse aligned with output pixel (0,0)
//
//  Pipeline: counters -> address register -> RAM read -> pin registers.
//  A counter state (h,v) reaches the pins exactly three clocks later, with
//  sync and colour carried through matching delay stages.
//
//  Revision    : 1.0  initial release
// ============================================================================
module vga_scanout #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDRESS_SIZE = 13,
    parameter int FB_WIDTH     = 80,
    parameter int SCALE_SHIFT  = 3,
    parameter int H_ACTIVE     = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic [ADDRESS_SIZE-1:0] fb_read_address,
    input  logic [DATA_WIDTH-1:0]   fb_data,
    output logic                    hsync,
    output logic                    vsync,
    output logic [3:0]              red,
    output logic [3:0]              green,
    output logic [3:0]              blue,
    output logic                    frame_start
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_h_bits  = $clog2(c_h_total);
    localparam int c_v_bits  = $clog2(c_v_total);

    localparam logic [c_h_bits-1:0] c_h_last     = c_h_bits'(c_h_total - 1);
    localparam logic [c_v_bits-1:0] c_v_last     = c_v_bits'(c_v_total - 1);
    localparam logic [c_h_bits-1:0] c_h_active   = c_h_bits'(H_ACTIVE);
    localparam logic [c_v_bits-1:0] c_v_active   = c_v_bits'(V_ACTIVE);
    localparam logic [c_h_bits-1:0] c_hs_start   = c_h_bits'(H_ACTIVE + H_FRONT);
    localparam logic [c_h_bits-1:0] c_hs_end     = c_h_bits'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [c_v_bits-1:0] c_vs_start   = c_v_bits'(V_ACTIVE + V_FRONT);
    localparam logic [c_v_bits-1:0] c_vs_end     = c_v_bits'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [ADDRESS_SIZE-1:0] c_fb_width = ADDRESS_SIZE'(FB_WIDTH);

    // ------------------------------------------------------------------
    // Stage 0: raster counters and framebuffer row base
    // ------------------------------------------------------------------
    logic [c_h_bits-1:0]     r_h;
    logic [c_v_bits-1:0]     r_v;
    logic [ADDRESS_SIZE-1:0] r_row_base;

    logic                    w_h_visible;
    logic                    w_v_visible;
    logic                    w_active;
    logic                    w_hs;
    logic                    w_vs;
    logic                    w_fs;
    logic [ADDRESS_SIZE-1:0] w_col;

    assign w_h_visible = (r_h < c_h_active);
    assign w_v_visible = (r_v < c_v_active);
    assign w_active    = w_h_visible && w_v_visible;
    assign w_hs        = !((r_h >= c_hs_start) && (r_h < c_hs_end));
    assign w_vs        = !((r_v >= c_vs_start) && (r_v < c_vs_end));
    assign w_fs        = (r_h == '0) && (r_v == '0);
    assign w_col       = ADDRESS_SIZE'(r_h >> SCALE_SHIFT);

    // The row base advances by one framebuffer row after the last of each
    // group of replicated lines, so the address never needs a multiplier.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h        <= '0;
            r_v        <= '0;
            r_row_base <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            if (r_v == c_v_last) begin
                r_v        <= '0;
                r_row_base <= '0;
            end else begin
                r_v <= r_v + 1'b1;
                if (w_v_visible && (r_v[SCALE_SHIFT-1:0] == '1)) begin
                    r_row_base <= r_row_base + c_fb_width;
                end
            end
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: address register plus delayed control
    // Stage 2: RAM read in flight, control delayed once more
    // ------------------------------------------------------------------
    logic r_active_d1, r_hs_d1, r_vs_d1, r_fs_d1;
    logic r_active_d2, r_hs_d2, r_vs_d2, r_fs_d2;

    always_ff @(posedge clock) begin
        if (reset) begin
            fb_read_address <= '0;
            r_active_d1     <= 1'b0;
            r_hs_d1         <= 1'b1;
            r_vs_d1         <= 1'b1;
            r_fs_d1         <= 1'b0;
            r_active_d2     <= 1'b0;
            r_hs_d2         <= 1'b1;
            r_vs_d2         <= 1'b1;
            r_fs_d2         <= 1'b0;
        end else begin
            // Blanked cycles park the address at 0.
            fb_read_address <= w_active ? (r_row_base + w_col) : '0;
            r_active_d1     <= w_active;
            r_hs_d1         <= w_hs;
            r_vs_d1         <= w_vs;
            r_fs_d1         <= w_fs;
            r_active_d2     <= r_active_d1;
            r_hs_d2         <= r_hs_d1;
            r_vs_d2         <= r_vs_d1;
            r_fs_d2         <= r_fs_d1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: pin registers. RAM data is only taken while active; any
    // value the RAM returns during blanking is discarded.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (r_active_d2) begin
                red   <= fb_data[DATA_WIDTH-1 -: 4];
                green <= fb_data[7:4];
                blue  <= fb_data[3:0];
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
            hsync       <= r_hs_d2;
            vsync       <= r_vs_d2;
            frame_start <= r_fs_d2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scanout
//  Description : Self-checking bench for vga_scanout. A full-size instance
//                covers reset, line addressing, hsync, row stepping and
//                mid-frame reset; a reduced-timing instance covers whole
//                frames (vsync, frame period, last visible line).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_scanout;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_big;
    logic        reset_small;
    logic [12:0] addr_big, addr_small;
    logic [11:0] data_big, data_small;
    logic        hs_big, vs_big, fs_big;
    logic        hs_small, vs_small, fs_small;
    logic [3:0]  r_big, g_big, b_big;
    logic [3:0]  r_small, g_small, b_small;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    // RAM contents are a fixed function of the address.
    function automatic logic [11:0] ram_word(input logic [12:0] a);
        return 12'((a * 13'd5) + 13'd1);
    endfunction

    // Synchronous-read RAM models, one clock of latency.
    always @(posedge clock) begin
        data_big   <= ram_word(addr_big);
        data_small <= ram_word(addr_small);
    end

    vga_scanout u_big (
        .clock           (clock),
        .reset           (reset_big),
        .fb_read_address (addr_big),
        .fb_data         (data_big),
        .hsync           (hs_big),
        .vsync           (vs_big),
        .red             (r_big),
        .green           (g_big),
        .blue            (b_big),
        .frame_start     (fs_big)
    );

    // Reduced raster: 24 clocks x 23 lines, 4x4 replication, 4x4 framebuffer.
    vga_scanout #(
        .FB_WIDTH    (4),
        .SCALE_SHIFT (2),
        .H_ACTIVE    (16),
        .H_FRONT     (2),
        .H_SYNC      (4),
        .H_BACK      (2),
        .V_ACTIVE    (16),
        .V_FRONT     (2),
        .V_SYNC      (2),
        .V_BACK      (3)
    ) u_small (
        .clock           (clock),
        .reset           (reset_small),
        .fb_read_address (addr_small),
        .fb_data         (data_small),
        .hsync           (hs_small),
        .vsync           (vs_small),
        .red             (r_small),
        .green           (g_small),
        .blue            (b_small),
        .frame_start     (fs_small)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_big();
        tick();
        edges++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_big   = 1'b1;
        reset_small = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (addr_big !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_addr: got %0d want 0", addr_big);
        end
        n_cmp++;
        if ({hs_big, vs_big, fs_big} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_sync: got hs/vs/fs=%b want 110", {hs_big, vs_big, fs_big});
        end
        n_cmp++;
        if ({r_big, g_big, b_big} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_rgb: got %h want 000", {r_big, g_big, b_big});
        end
        @(negedge clock);
        reset_big = 1'b0;
        edges = 0;
        for (int k = 1; k <= 3; k++) begin
            tick_big();
            n_cmp++;
            if ({hs_big, vs_big} !== 2'b11) begin
                n_bad++;
                $display("FAIL start_sync c%0d: got %b want 11", k, {hs_big, vs_big});
            end
            if (k == 1) begin
                n_cmp++;
                if (addr_big !== 13'd0) begin
                    n_bad++;
                    $display("FAIL start_addr: got %0d want 0", addr_big);
                end
            end
            n_cmp++;
            if (fs_big !== (k == 3)) begin
                n_bad++;
                $display("FAIL start_fs c%0d: got %b want %b", k, fs_big, (k == 3));
            end
            if (k == 3) begin
                n_cmp++;
                if ({r_big, g_big, b_big} !== ram_word(13'd0)) begin
                    n_bad++;
                    $display("FAIL start_rgb: got %h want %h", {r_big, g_big, b_big}, ram_word(13'd0));
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Line 0: address h/8 for visible h, 0 in blanking; colour follows 3 later.
    task automatic test_line0_addresses();
        int h;
        int t;
        logic [11:0] exp_rgb;
        logic        exp_hs;
        while (edges < 800) begin
            tick_big();
            h = edges - 1;
            n_cmp++;
            if (addr_big !== 13'((h < 640) ? (h / 8) : 0)) begin
                n_bad++;
                $display("FAIL line0_addr h=%0d: got %0d want %0d", h, addr_big, (h < 640) ? (h / 8) : 0);
            end
            t = edges - 3;
            exp_rgb = (t < 640) ? ram_word(13'(t / 8)) : 12'h000;
            exp_hs  = !((t >= 656) && (t <= 751));
            n_cmp++;
            if ({r_big, g_big, b_big} !== exp_rgb || hs_big !== exp_hs) begin
                n_bad++;
                $display("FAIL line0_pins h=%0d: got rgb=%h hs=%b want rgb=%h hs=%b",
                         t, {r_big, g_big, b_big}, hs_big, exp_rgb, exp_hs);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_hsync();
        int  fall1 = -1;
        int  fall2 = -1;
        int  width = 0;
        logic prev = hs_big;
        logic vs_seen_low = 1'b0;
        while (edges < 2400) begin
            tick_big();
            if (prev && !hs_big) begin
                if (fall1 < 0) fall1 = edges;
                else if (fall2 < 0) fall2 = edges;
            end
            if (!hs_big && fall2 < 0) width++;
            if (!vs_big) vs_seen_low = 1'b1;
            prev = hs_big;
        end
        n_cmp++;
        if (fall1 !== 1459) begin
            n_bad++;
            $display("FAIL hsync_fall: got %0d want 1459", fall1);
        end
        n_cmp++;
        if (width !== 96) begin
            n_bad++;
            $display("FAIL hsync_width: got %0d want 96", width);
        end
        n_cmp++;
        if ((fall2 - fall1) !== 800) begin
            n_bad++;
            $display("FAIL hsync_period: got %0d want 800", fall2 - fall1);
        end
        n_cmp++;
        if (vs_seen_low !== 1'b0) begin
            n_bad++;
            $display("FAIL vsync_early: got low want high");
        end
    endtask

    // ------------------------------------------------------------------
    // Lines 7 and 8: row base steps from 0 to 80 between them.
    task automatic test_row_base();
        while (edges < 7040) begin
            tick_big();
            case (edges)
                5601: begin
                    n_cmp++;
                    if (addr_big !== 13'd0) begin
                        n_bad++;
                        $display("FAIL line7_start: got %0d want 0", addr_big);
                    end
                end
                6240: begin
                    n_cmp++;
                    if (addr_big !== 13'd79) begin
                        n_bad++;
                        $display("FAIL line7_end: got %0d want 79", addr_big);
                    end
                end
                6401: begin
                    n_cmp++;
                    if (addr_big !== 13'd80) begin
                        n_bad++;
                        $display("FAIL line8_start: got %0d want 80", addr_big);
                    end
                end
                6403: begin
                    n_cmp++;
                    if ({r_big, g_big, b_big} !== ram_word(13'd80)) begin
                        n_bad++;
                        $display("FAIL line8_rgb: got %h want %h", {r_big, g_big, b_big}, ram_word(13'd80));
                    end
                end
                7040: begin
                    n_cmp++;
                    if (addr_big !== 13'd159) begin
                        n_bad++;
                        $display("FAIL line8_end: got %0d want 159", addr_big);
                    end
                end
                default: ;
            endcase
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_mid_frame_reset();
        // First reset at h=300, line 9.
        while (edges < 7500) tick_big();
        @(negedge clock);
        reset_big = 1'b1;
        tick();
        @(negedge clock);
        reset_big = 1'b0;
        edges = 0;
        n_cmp++;
        if ({r_big, g_big, b_big, hs_big, vs_big, fs_big} !== {12'h000, 3'b110}) begin
            n_bad++;
            $display("FAIL midreset_flush: got rgb=%h hs/vs/fs=%b want 000 110",
                     {r_big, g_big, b_big}, {hs_big, vs_big, fs_big});
        end
        for (int k = 1; k <= 3; k++) begin
            tick_big();
            n_cmp++;
            if (fs_big !== (k == 3) || {hs_big, vs_big} !== 2'b11) begin
                n_bad++;
                $display("FAIL midreset_c%0d: got fs=%b hs/vs=%b want fs=%b hs/vs=11",
                         k, fs_big, {hs_big, vs_big}, (k == 3));
            end
            n_cmp++;
            if ({r_big, g_big, b_big} !== ((k == 3) ? ram_word(13'd0) : 12'h000)) begin
                n_bad++;
                $display("FAIL midreset_rgb c%0d: got %h want %h", k, {r_big, g_big, b_big},
                         (k == 3) ? ram_word(13'd0) : 12'h000);
            end
        end
        // Second reset inside the hsync pulse: no stale low may leak out.
        while (edges < 700) tick_big();
        n_cmp++;
        if (hs_big !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_reset_hsync: got %b want 0", hs_big);
        end
        @(negedge clock);
        reset_big = 1'b1;
        tick();
        @(negedge clock);
        reset_big = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) tick();
            n_cmp++;
            if ({hs_big, vs_big} !== 2'b11 || fs_big !== (k == 3)) begin
                n_bad++;
                $display("FAIL sync_glitch c%0d: got hs/vs=%b fs=%b want 11 fs=%b",
                         k, {hs_big, vs_big}, fs_big, (k == 3));
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Reduced raster: frame 552 clocks, vsync on lines 18-19, visible 16 lines.
    task automatic test_small_frame();
        int   n      = 0;
        int   t;
        int   v;
        int   fall1  = -1;
        int   fall2  = -1;
        int   width  = 0;
        int   fs_cnt = 0;
        int   max_addr = 0;
        logic prev   = 1'b1;
        @(negedge clock);
        reset_small = 1'b0;
        while (n < 1200) begin
            tick();
            n++;
            if (prev && !vs_small) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!vs_small && fall2 < 0) width++;
            prev = vs_small;
            if (fs_small) fs_cnt++;
            if (int'(addr_small) > max_addr) max_addr = int'(addr_small);
            n_cmp++;
            if (fs_small !== (n == 3 || n == 555 || n == 1107)) begin
                n_bad++;
                $display("FAIL small_fs n=%0d: got %b", n, fs_small);
            end
            t = n - 3;
            v = (t / 24) % 23;
            if (t >= 0 && v >= 16) begin
                n_cmp++;
                if ({r_small, g_small, b_small} !== 12'h000) begin
                    n_bad++;
                    $display("FAIL small_blank v=%0d: got %h want 000", v, {r_small, g_small, b_small});
                end
            end
            if (n == 97) begin
                n_cmp++;
                if (addr_small !== 13'd4) begin
                    n_bad++;
                    $display("FAIL small_line4: got %0d want 4", addr_small);
                end
            end
            if (n == 361) begin
                n_cmp++;
                if (addr_small !== 13'd12) begin
                    n_bad++;
                    $display("FAIL small_line15: got %0d want 12", addr_small);
                end
            end
        end
        n_cmp++;
        if (fall1 !== 435) begin
            n_bad++;
            $display("FAIL small_vs_fall: got %0d want 435", fall1);
        end
        n_cmp++;
        if (width !== 48) begin
            n_bad++;
            $display("FAIL small_vs_width: got %0d want 48", width);
        end
        n_cmp++;
        if ((fall2 - fall1) !== 552) begin
            n_bad++;
            $display("FAIL small_frame_period: got %0d want 552", fall2 - fall1);
        end
        n_cmp++;
        if (fs_cnt !== 3) begin
            n_bad++;
            $display("FAIL small_fs_count: got %0d want 3", fs_cnt);
        end
        n_cmp++;
        if (max_addr !== 15) begin
            n_bad++;
            $display("FAIL small_max_addr: got %0d want 15", max_addr);
        end
    endtask

    initial begin
        reset_big   = 1'b1;
        reset_small = 1'b1;
        test_reset();
        test_line0_addresses();
        test_hsync();
        test_row_base();
        test_mid_frame_reset();
        test_small_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
